// File: rtl/draw_text_box_if.sv
// Pixel-stream and external memory signals of the text-box overlay.
// master = upstream stage plus char/font memories, slave = draw_text_box.
interface draw_text_box_if;
    logic        hsync_in;
    logic        vsync_in;
    logic [15:0] hcount_in;
    logic [15:0] vcount_in;
    logic [11:0] rgb_in;
    logic        opaque;
    logic [7:0]  char_xy;
    logic [7:0]  char_code;
    logic [10:0] font_addr;
    logic [7:0]  font_pixels;
    logic        hsync_out;
    logic        vsync_out;
    logic [15:0] hcount_out;
    logic [15:0] vcount_out;
    logic [11:0] rgb_out;

    modport master (
        output hsync_in, vsync_in, hcount_in, vcount_in, rgb_in, opaque,
        output char_code, font_pixels,
        input  char_xy, font_addr,
        input  hsync_out, vsync_out, hcount_out, vcount_out, rgb_out
    );

    modport slave (
        input  hsync_in, vsync_in, hcount_in, vcount_in, rgb_in, opaque,
        input  char_code, font_pixels,
        output char_xy, font_addr,
        output hsync_out, vsync_out, hcount_out, vcount_out, rgb_out
    );
endinterface

// File: rtl/draw_text_box.sv
// Text overlay: box pixels -> char/font addresses -> glyph over rgb_in; fixed 4-cycle latency, no backpressure.
// Optional TEXT_BLINK_EN: hides char_code[7] glyphs during frames 16-31 of every 32 (vsync_in rising edges).
module draw_text_box #(
    parameter int          COLS       = 16,
    parameter int          ROWS       = 16,
    parameter int          SCALE      = 1,
    parameter int          START_X    = 850,
    parameter int          START_Y    = 30,
    parameter logic [11:0] FONT_COLOR = 12'hfff,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic           clk,
    input  logic           rst,
    draw_text_box_if.slave bus
);
    localparam int          SHIFT = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
    localparam int          BOX_W = COLS * 8 * SCALE;
    localparam int          BOX_H = ROWS * 16 * SCALE;
    localparam logic [15:0] X_LO  = 16'(START_X);
    localparam logic [15:0] X_HI  = 16'(START_X + BOX_W - 1);
    localparam logic [15:0] Y_LO  = 16'(START_Y);
    localparam logic [15:0] Y_HI  = 16'(START_Y + BOX_H - 1);

    logic        w_in_box;
    logic [15:0] w_rx;
    logic [15:0] w_ry;
    logic [15:0] w_col;
    logic [15:0] w_row;
    logic [7:0]  w_char_xy;
    logic [2:0]  w_px;
    logic [3:0]  w_line;
    logic        w_glyph_bit;
    logic        w_hidden;
    logic        w_blink_off;
    logic [11:0] w_rgb_next;

    logic        r_in1, r_in2, r_in3;
    logic [2:0]  r_px1, r_px2, r_px3;
    logic [3:0]  r_line1;
    logic        r_blink2, r_blink3;
    logic [7:0]  r_char_xy;
    logic [10:0] r_font_addr;
    logic [7:0]  r_pix3;
    logic [11:0] r_rgb_out;
    logic [3:0]  r_hs_d;
    logic [3:0]  r_vs_d;
    logic [15:0] r_hc_d [4];
    logic [15:0] r_vc_d [4];
    logic [11:0] r_rgb_d [3];
    logic [2:0]  r_op_d;

    // Bounds use the raw coordinates so pixels left of / above the box cannot wrap in.
    assign w_in_box  = (bus.hcount_in >= X_LO) && (bus.hcount_in <= X_HI) &&
                       (bus.vcount_in >= Y_LO) && (bus.vcount_in <= Y_HI);
    assign w_rx      = bus.hcount_in - X_LO;
    assign w_ry      = bus.vcount_in - Y_LO;
    assign w_col     = w_rx >> (3 + SHIFT);
    assign w_row     = w_ry >> (4 + SHIFT);
    assign w_char_xy = w_in_box ? 8'(w_row * 16'(COLS) + w_col) : 8'd0;
    assign w_px      = 3'(w_rx >> SHIFT);
    assign w_line    = 4'(w_ry >> SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in1       <= 1'b0;
            r_in2       <= 1'b0;
            r_in3       <= 1'b0;
            r_px1       <= '0;
            r_px2       <= '0;
            r_px3       <= '0;
            r_line1     <= '0;
            r_blink2    <= 1'b0;
            r_blink3    <= 1'b0;
            r_char_xy   <= '0;
            r_font_addr <= '0;
            r_pix3      <= '0;
            r_rgb_out   <= '0;
            r_hs_d      <= '0;
            r_vs_d      <= '0;
            r_op_d      <= '0;
            for (int i = 0; i < 4; i++) begin
                r_hc_d[i] <= '0;
                r_vc_d[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                r_rgb_d[i] <= '0;
            end
        end else begin
            r_char_xy   <= w_char_xy;
            r_in1       <= w_in_box;
            r_px1       <= w_px;
            r_line1     <= w_line;

            // char_code answers the address registered on the previous edge.
            r_font_addr <= {bus.char_code[6:0], r_line1};
            r_in2       <= r_in1;
            r_px2       <= r_px1;
            r_blink2    <= bus.char_code[7];

            r_pix3      <= bus.font_pixels;
            r_in3       <= r_in2;
            r_px3       <= r_px2;
            r_blink3    <= r_blink2;

            r_rgb_out   <= w_rgb_next;

            r_hs_d      <= {r_hs_d[2:0], bus.hsync_in};
            r_vs_d      <= {r_vs_d[2:0], bus.vsync_in};
            r_op_d      <= {r_op_d[1:0], bus.opaque};
            r_hc_d[0]   <= bus.hcount_in;
            r_vc_d[0]   <= bus.vcount_in;
            for (int i = 1; i < 4; i++) begin
                r_hc_d[i] <= r_hc_d[i-1];
                r_vc_d[i] <= r_vc_d[i-1];
            end
            r_rgb_d[0]  <= bus.rgb_in;
            r_rgb_d[1]  <= r_rgb_d[0];
            r_rgb_d[2]  <= r_rgb_d[1];
        end
    end

`ifdef TEXT_BLINK_EN
    logic [4:0] r_frame_cnt;

    // r_vs_d[0] is the previous vsync_in sample, used as the edge reference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (bus.vsync_in && !r_vs_d[0]) begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
        end
    end

    assign w_blink_off = r_frame_cnt[4];
`else
    assign w_blink_off = 1'b0;
`endif

    assign w_glyph_bit = r_pix3[3'd7 - r_px3];
    assign w_hidden    = r_blink3 & w_blink_off;

    always_comb begin
        w_rgb_next = r_rgb_d[2];
        if (r_in3) begin
            if (w_glyph_bit && !w_hidden) begin
                w_rgb_next = FONT_COLOR;
            end else if (r_op_d[2]) begin
                w_rgb_next = BG_COLOR;
            end
        end
    end

    assign bus.char_xy    = r_char_xy;
    assign bus.font_addr  = r_font_addr;
    assign bus.rgb_out    = r_rgb_out;
    assign bus.hsync_out  = r_hs_d[3];
    assign bus.vsync_out  = r_vs_d[3];
    assign bus.hcount_out = r_hc_d[3];
    assign bus.vcount_out = r_vc_d[3];
endmodule

// File: tb/tb_draw_text_box.sv
// Scoreboard bench: default instance plus a SCALE=2 instance with distinct colours, sharing char/font memories.
module tb_draw_text_box;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    draw_text_box_if bus_a ();
    draw_text_box_if bus_b ();

    draw_text_box dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    draw_text_box #(
        .SCALE      (2),
        .FONT_COLOR (12'hf0f),
        .BG_COLOR   (12'h123)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    logic [7:0] char_mem [256];
    logic [7:0] font_rom [2048];

    // One-cycle-latency memories: the DUT's address register is the read address register.
    assign bus_a.char_code   = char_mem[bus_a.char_xy];
    assign bus_a.font_pixels = font_rom[bus_a.font_addr];
    assign bus_b.char_code   = char_mem[bus_b.char_xy];
    assign bus_b.font_pixels = font_rom[bus_b.font_addr];

    typedef struct {
        logic [7:0]  xy_a, xy_b;
        logic [10:0] fa_a, fa_b;
        logic [11:0] rgb_a, rgb_b;
        logic        hs, vs;
        logic [15:0] hc, vc;
    } exp_t;

    exp_t q_xy [$];
    exp_t q_fa [$];
    exp_t q_out [$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   frames = 0;
    logic vs_prev = 1'b0;

    int pts [12][2] = '{'{977, 285}, '{978, 285}, '{849, 30}, '{850, 29},
                        '{850, 285}, '{850, 286}, '{1105, 541}, '{1106, 541},
                        '{1105, 542}, '{0, 0}, '{65535, 40}, '{900, 65535}};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model(input int hc, input int vc, input logic [11:0] rin, input logic op,
                                  input int sc, input logic [11:0] fg, input logic [11:0] bg,
                                  output logic [7:0] xy, output logic [10:0] fa, output logic [11:0] rgb);
        int         rx, ry, px;
        bit         inb, hidden;
        logic [7:0] code, pix;
        logic [3:0] line;
        inb  = (hc >= 850) && (hc <= 850 + 128 * sc - 1) && (vc >= 30) && (vc <= 30 + 256 * sc - 1);
        rx   = (hc - 850) & 32'hffff;
        ry   = (vc - 30) & 32'hffff;
        xy   = inb ? 8'((ry / (16 * sc)) * 16 + rx / (8 * sc)) : 8'd0;
        code = char_mem[xy];
        line = 4'((ry / sc) % 16);
        fa   = {code[6:0], line};
        pix  = font_rom[fa];
        px   = (rx / sc) % 8;
        hidden = 1'b0;
`ifdef TEXT_BLINK_EN
        hidden = code[7] && ((frames % 32) >= 16);
`endif
        if (!inb)                     rgb = rin;
        else if (pix[7-px] && !hidden) rgb = fg;
        else if (op)                  rgb = bg;
        else                          rgb = rin;
    endfunction

    task automatic drive(input int hc, input int vc, input logic hs, input logic vs, input logic op);
        exp_t        e;
        logic [7:0]  xy;
        logic [10:0] fa;
        logic [11:0] rgb, rin;
        rin = 12'($urandom);
        @(negedge clk);
        bus_a.hcount_in = 16'(hc);  bus_b.hcount_in = 16'(hc);
        bus_a.vcount_in = 16'(vc);  bus_b.vcount_in = 16'(vc);
        bus_a.hsync_in  = hs;       bus_b.hsync_in  = hs;
        bus_a.vsync_in  = vs;       bus_b.vsync_in  = vs;
        bus_a.opaque    = op;       bus_b.opaque    = op;
        bus_a.rgb_in    = rin;      bus_b.rgb_in    = rin;
        if (vs && !vs_prev) frames++;
        vs_prev = vs;
        model(hc, vc, rin, op, 1, 12'hfff, 12'h000, xy, fa, rgb);
        e.xy_a = xy; e.fa_a = fa; e.rgb_a = rgb;
        model(hc, vc, rin, op, 2, 12'hf0f, 12'h123, xy, fa, rgb);
        e.xy_b = xy; e.fa_b = fa; e.rgb_b = rgb;
        e.hs = hs; e.vs = vs; e.hc = 16'(hc); e.vc = 16'(vc);
        q_xy.push_back(e);
        q_fa.push_back(e);
        q_out.push_back(e);
        @(posedge clk);
        #1;
        e = q_xy.pop_front();
        check_val("char_xy_a", bus_a.char_xy, e.xy_a);
        check_val("char_xy_b", bus_b.char_xy, e.xy_b);
        if (q_fa.size() >= 2) begin
            e = q_fa.pop_front();
            check_val("font_addr_a", bus_a.font_addr, e.fa_a);
            check_val("font_addr_b", bus_b.font_addr, e.fa_b);
        end
        e = q_out.pop_front();
        check_val("rgb_out_a", bus_a.rgb_out, e.rgb_a);
        check_val("rgb_out_b", bus_b.rgb_out, e.rgb_b);
        check_val("hsync_out", bus_a.hsync_out, e.hs);
        check_val("vsync_out", bus_a.vsync_out, e.vs);
        check_val("hcount_out", bus_a.hcount_out, e.hc);
        check_val("vcount_out", bus_a.vcount_out, e.vc);
    endtask

    task automatic apply_reset();
        exp_t z;
        z = '{default: '0};
        rst = 1'b1;
        #1;
        check_val("rst_char_xy", bus_a.char_xy, 0);
        check_val("rst_font_addr", bus_a.font_addr, 0);
        check_val("rst_rgb_out_a", bus_a.rgb_out, 0);
        check_val("rst_rgb_out_b", bus_b.rgb_out, 0);
        check_val("rst_hsync_out", bus_a.hsync_out, 0);
        check_val("rst_vsync_out", bus_a.vsync_out, 0);
        check_val("rst_hcount_out", bus_a.hcount_out, 0);
        check_val("rst_vcount_out", bus_a.vcount_out, 0);
        q_xy.delete();
        q_fa.delete();
        q_out.delete();
        frames  = 0;
        vs_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // Flushed stages emit zeros until the first post-reset sample emerges.
        repeat (3) q_out.push_back(z);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)  char_mem[i] = 8'(i * 37 + 5);
        for (int j = 0; j < 2048; j++) font_rom[j] = 8'((j * 97) ^ (j >> 4));
        char_mem[0]        = 8'h41;
        char_mem[17]       = 8'hC1;
        font_rom[11'h410]  = 8'h80;
        bus_a.hcount_in = '0; bus_b.hcount_in = '0;
        bus_a.vcount_in = '0; bus_b.vcount_in = '0;
        bus_a.hsync_in  = 0;  bus_b.hsync_in  = 0;
        bus_a.vsync_in  = 0;  bus_b.vsync_in  = 0;
        bus_a.opaque    = 0;  bus_b.opaque    = 0;
        bus_a.rgb_in    = '0; bus_b.rgb_in    = '0;

        #2 apply_reset();

        drive(850, 30, 1'b0, 1'b0, 1'b0);
        drive(851, 30, 1'b0, 1'b0, 1'b0);

        for (int hc = 846; hc <= 980; hc++)
            drive(hc, 30, 1'($urandom), 1'b0, 1'b0);
        for (int hc = 846; hc <= 1108; hc++)
            drive(hc, 45, 1'($urandom), 1'b0, 1'b1);

        for (int k = 0; k < 12; k++)
            drive(pts[k][0], pts[k][1], 1'($urandom), 1'b0, 1'($urandom));

        for (int k = 0; k < 60; k++)
            drive(int'($urandom_range(1110, 840)), int'($urandom_range(550, 25)),
                  1'($urandom), 1'b0, 1'($urandom));

        drive(900, 100, 1'b1, 1'b0, 1'b0);
        apply_reset();
        for (int k = 0; k < 8; k++)
            drive(900, 600, 1'($urandom), 1'b0, 1'b0);

        // Blink target at char 17 (code C1) sampled once per frame, away from vsync edges.
        for (int f = 0; f < 34; f++) begin
            drive(858, 46, 1'b0, 1'b0, 1'b0);
            drive(0, 0, 1'b0, 1'b1, 1'b0);
            repeat (4) drive(0, 0, 1'b0, 1'b0, 1'b0);
        end

        repeat (4) drive(0, 0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
